// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the sr_ff bank write driver.
// The per-bit excitation function is also used by the bench for expected values.
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } sr_state_e;

  localparam logic [1:0] EXC_HOLD  = 2'b00;
  localparam logic [1:0] EXC_SET   = 2'b10;
  localparam logic [1:0] EXC_RESET = 2'b01;

  // Returns {s, r} for one cell; both high is impossible by construction.
  function automatic logic [1:0] sr_excite(input logic tgt, input logic q);
    return {tgt & ~q, ~tgt & q};
  endfunction

endpackage

// File: rtl/sr_settle_timer.sv
// Down-counter that holds the driver in SETTLE for CYCLES cycles after a load.
// expired is high during the last SETTLE cycle.
module sr_settle_timer #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(CYCLES);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  assign expired = en && (cnt_q <= CW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sr_ff_bank_driver.sv
// Write-side controller for a bank of sr_ff cells: drives legal S/R pulses toward a target
// word, reads Q back, retries up to MAX_RETRY times and reports done/err.
module sr_ff_bank_driver
  import sr_drv_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  sr_state_e        state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] exc_tgt, exc_s, exc_r;
  logic             settle_expired;

  // In IDLE the excitation targets the incoming word; in CHECK the latched one.
  assign exc_tgt = (state_q == IDLE) ? req_data : tgt_q;

  always_comb begin
    exc_s = '0;
    exc_r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {exc_s[i], exc_r[i]} = sr_excite(exc_tgt[i], q_in[i]);
    end
  end

  sr_settle_timer #(.CYCLES(SETTLE_CYCLES)) u_settle (
    .clk     (clk),
    .reset   (reset),
    .load    (state_q == DRIVE),
    .en      (state_q == SETTLE),
    .expired (settle_expired)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    err_d   = err_q;
    s_d     = '0;
    r_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          tgt_d = req_data;
          err_d = 1'b0;
          if ((exc_s | exc_r) != '0) begin
            s_d     = exc_s;
            r_d     = exc_r;
            state_d = DRIVE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DRIVE:  state_d = SETTLE;
      SETTLE: if (settle_expired) state_d = CHECK;
      CHECK: begin
        if (q_in == tgt_q) begin
          err_d   = 1'b0;
          state_d = DONE;
        end else if (retry_q != RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          s_d     = exc_s;
          r_d     = exc_r;
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

  assign s_out     = s_q;
  assign r_out     = r_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_sr_ff_bank_driver.sv
// Directed bench for sr_ff_bank_driver with a behavioural 8-cell sr_ff bank on q_in.
module tb_sr_ff_bank_driver;
  import sr_drv_pkg::*;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [7:0] q_in;
  logic [7:0] s_out;
  logic [7:0] r_out;
  logic       busy;
  logic       done;
  logic       err;

  logic [7:0] bank_q;
  logic [7:0] stuck0_mask;
  logic       preload_en;
  logic [7:0] preload_val;

  int checks = 0;
  int errors = 0;

  sr_ff_bank_driver #(.WIDTH(8), .SETTLE_CYCLES(1), .MAX_RETRY(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .q_in      (q_in),
    .s_out     (s_out),
    .r_out     (r_out),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank of sr_ff cells: S sets, R clears, neither holds.
  always @(posedge clk) begin
    if (preload_en) bank_q <= preload_val;
    else            bank_q <= (bank_q & ~r_out) | s_out;
  end
  assign q_in = bank_q & ~stuck0_mask;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] v);
    preload_val = v;
    preload_en  = 1'b1;
    tick();
    preload_en  = 1'b0;
  endtask

  // Offers one request, then watches outputs each cycle until done or a 40-cycle bound.
  task automatic run_request(input logic [7:0] data, output int lat, output int drives,
                             output logic [7:0] s_seen, output logic [7:0] r_seen,
                             output bit overlap, output logic err_at_done);
    req_data  = data;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_data  = ~data;
    lat = 0; drives = 0; s_seen = '0; r_seen = '0; overlap = 0; err_at_done = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      if ((s_out & r_out) != 8'h00) overlap = 1;
      if ((s_out | r_out) != 8'h00) begin
        if (drives == 0) begin
          s_seen = s_out;
          r_seen = r_out;
        end
        drives++;
      end
      if (done === 1'b1) begin
        lat = k;
        err_at_done = err;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_data = 8'h00; stuck0_mask = 8'h00;
    preload_val = 8'h00; preload_en = 1'b1;
    tick();
    tick();
    preload_en = 1'b0;
    checks++; if (s_out !== 8'h00) begin errors++; $display("FAIL reset_s got %h want 00", s_out); end
    checks++; if (r_out !== 8'h00) begin errors++; $display("FAIL reset_r got %h want 00", r_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_set_a5();
    int lat, drives; logic [7:0] s_seen, r_seen; bit ov; logic e;
    preload(8'h00);
    run_request(8'hA5, lat, drives, s_seen, r_seen, ov, e);
    checks++; if (lat != 4) begin errors++; $display("FAIL a5_latency got %0d want 4", lat); end
    checks++; if (drives != 1) begin errors++; $display("FAIL a5_drives got %0d want 1", drives); end
    checks++; if (s_seen !== 8'hA5) begin errors++; $display("FAIL a5_s got %h want a5", s_seen); end
    checks++; if (r_seen !== 8'h00) begin errors++; $display("FAIL a5_r got %h want 00", r_seen); end
    checks++; if (ov) begin errors++; $display("FAIL a5_overlap got 1 want 0"); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL a5_err got %b want 0", e); end
    checks++; if (q_in !== 8'hA5) begin errors++; $display("FAIL a5_q got %h want a5", q_in); end
    tick();
  endtask

  task automatic test_transition_5a();
    int lat, drives; logic [7:0] s_seen, r_seen, s_exp, r_exp; bit ov; logic e;
    // From A5 to 5A every bit flips: s=5A, r=A5.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] t, q;
      t = 8'h5A; q = 8'hA5;
      {s_exp[i], r_exp[i]} = sr_excite(t[i], q[i]);
    end
    run_request(8'h5A, lat, drives, s_seen, r_seen, ov, e);
    checks++; if (lat != 4) begin errors++; $display("FAIL 5a_latency got %0d want 4", lat); end
    checks++; if (s_seen !== s_exp) begin errors++; $display("FAIL 5a_s got %h want %h", s_seen, s_exp); end
    checks++; if (r_seen !== r_exp) begin errors++; $display("FAIL 5a_r got %h want %h", r_seen, r_exp); end
    checks++; if (ov) begin errors++; $display("FAIL 5a_overlap got 1 want 0"); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL 5a_err got %b want 0", e); end
    checks++; if (q_in !== 8'h5A) begin errors++; $display("FAIL 5a_q got %h want 5a", q_in); end
    tick();
  endtask

  task automatic test_noop();
    int lat, drives; logic [7:0] s_seen, r_seen; bit ov; logic e;
    preload(8'h3C);
    run_request(8'h3C, lat, drives, s_seen, r_seen, ov, e);
    checks++; if (lat != 1) begin errors++; $display("FAIL noop_latency got %0d want 1", lat); end
    checks++; if (drives != 0) begin errors++; $display("FAIL noop_drives got %0d want 0", drives); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL noop_err got %b want 0", e); end
    checks++; if (q_in !== 8'h3C) begin errors++; $display("FAIL noop_q got %h want 3c", q_in); end
    tick();
  endtask

  task automatic test_retry_error();
    int lat, drives; logic [7:0] s_seen, r_seen; bit ov; logic e;
    preload(8'h00);
    stuck0_mask = 8'h01;
    run_request(8'h01, lat, drives, s_seen, r_seen, ov, e);
    checks++; if (lat != 13) begin errors++; $display("FAIL retry_latency got %0d want 13", lat); end
    checks++; if (drives != 4) begin errors++; $display("FAIL retry_drives got %0d want 4", drives); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL retry_err got %b want 1", e); end
    tick(); tick(); tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL err_sticky_done got %b want 0", done); end
    stuck0_mask = 8'h00;
    run_request(8'h01, lat, drives, s_seen, r_seen, ov, e);
    checks++; if (lat != 1) begin errors++; $display("FAIL err_clear_latency got %0d want 1", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", e); end
    tick();
  endtask

  task automatic test_reset_abort();
    int done_seen;
    preload(8'h00);
    req_data = 8'hFF; req_valid = 1'b1;
    tick();
    req_data = 8'h00;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", req_ready); end
    checks++; if (s_out !== 8'hFF) begin errors++; $display("FAIL abort_drive_s got %h want ff", s_out); end
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL settle_busy got %b want 1", busy); end
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if ((s_out | r_out) !== 8'h00) begin errors++; $display("FAIL abort_sr got %h want 00", s_out | r_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_priority got busy %b want 0", busy); end
    reset = 1'b0; req_valid = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_set_a5();
    test_transition_5a();
    test_noop();
    test_retry_error();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
